// File: rtl/avalon_line_queue_controller.sv
// Avalon-MM line command queue with go/done dispatch to the drawer; LINE_QUEUE_IRQ_EN adds the drained interrupt.
// Latency: GO into an empty idle queue raises o_go 2 edges later; backpressure: full-queue GO stalls (MODE.bit0=0) or drops (poll).
module avalon_line_queue_controller #(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int COLOUR_W = 3,
  parameter int DEPTH    = 4
) (
  input  logic                clock,
  input  logic                i_reset_n,
  input  logic                i_chipselect,
  input  logic [2:0]          i_address,
  input  logic                i_read,
  input  logic                i_write,
  input  logic [31:0]         i_writedata,
  output logic [31:0]         o_readdata,
  output logic                o_waitrequest,
`ifdef LINE_QUEUE_IRQ_EN
  output logic                o_irq,
`endif
  input  logic                i_done,
  output logic                o_go,
  output logic [COLOUR_W-1:0] o_colour,
  output logic [X_W-1:0]      o_X0,
  output logic [Y_W-1:0]      o_Y0,
  output logic [X_W-1:0]      o_X1,
  output logic [Y_W-1:0]      o_Y1
);

  localparam int XY_W = X_W + Y_W;
  localparam int E_W  = COLOUR_W + 2 * XY_W;
  localparam int LW   = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t              state_q, state_d;
  logic                poll_q, overflow_q;
  logic [XY_W-1:0]     start_q, end_q;
  logic [COLOUR_W-1:0] colour_q;
  logic [E_W-1:0]      mem_q [DEPTH];
  logic [E_W-1:0]      cmd_q;
  logic [LW:0]         wr_ptr_q, rd_ptr_q, level;
  logic                wr_en, go_wr, full, empty, push, pop, idle;
  logic                irq_en, drained;
  logic                unused_wdata;

  assign unused_wdata  = ^i_writedata;
  assign wr_en         = i_chipselect & i_write;
  assign go_wr         = wr_en & (i_address == 3'd2);
  assign level         = wr_ptr_q - rd_ptr_q;
  assign full          = (level == (LW+1)'(DEPTH));
  assign empty         = (level == '0);
  // Full is judged on the registered level, so a same-edge pop never admits a push.
  assign push          = go_wr & ~full;
  assign o_waitrequest = go_wr & full & ~poll_q;
  assign idle          = empty & (state_q == S_IDLE);
  assign o_go          = (state_q == S_BUSY);
  assign {o_colour, o_Y0, o_X0, o_Y1, o_X1} = cmd_q;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: if (!empty) begin
        pop     = 1'b1;
        state_d = S_BUSY;
      end
      S_BUSY: if (i_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= S_IDLE;
      poll_q     <= 1'b0;
      overflow_q <= 1'b0;
      start_q    <= '0;
      end_q      <= '0;
      colour_q   <= '0;
      cmd_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (wr_en) begin
        case (i_address)
          3'd0: poll_q <= i_writedata[0];
          3'd1: if (i_writedata[1]) overflow_q <= 1'b0;
          3'd3: start_q <= i_writedata[XY_W-1:0];
          3'd4: end_q <= i_writedata[XY_W-1:0];
          3'd5: colour_q <= i_writedata[COLOUR_W-1:0];
          default: ;
        endcase
      end
      if (go_wr && full && poll_q) overflow_q <= 1'b1;
      if (push) begin
        mem_q[wr_ptr_q[LW-1:0]] <= {colour_q, start_q, end_q};
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        cmd_q    <= mem_q[rd_ptr_q[LW-1:0]];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

`ifdef LINE_QUEUE_IRQ_EN
  logic irq_en_q, drained_q;

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      irq_en_q  <= 1'b0;
      drained_q <= 1'b0;
    end else begin
      if (wr_en && i_address == 3'd0) irq_en_q <= i_writedata[1];
      if (wr_en && i_address == 3'd1 && i_writedata[2]) drained_q <= 1'b0;
      // Last line finished with nothing left behind it and nothing arriving this edge.
      if (state_q == S_BUSY && i_done && empty && !push) drained_q <= 1'b1;
    end
  end

  assign irq_en  = irq_en_q;
  assign drained = drained_q;
  assign o_irq   = drained_q & irq_en_q;
`else
  assign irq_en  = 1'b0;
  assign drained = 1'b0;
`endif

  always_comb begin
    o_readdata = '0;
    if (i_chipselect && i_read) begin
      case (i_address)
        3'd0: o_readdata = {30'b0, irq_en, poll_q};
        3'd1: o_readdata = {16'b0, 8'(level), 5'b0, drained, overflow_q, idle};
        3'd3: o_readdata = 32'(start_q);
        3'd4: o_readdata = 32'(end_q);
        3'd5: o_readdata = 32'(colour_q);
        3'd6: o_readdata = 32'(level);
        default: o_readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_line_queue_controller.sv
// Directed sequence with randomized line commands, checked against a queue-level model of the controller.
module tb_avalon_line_queue_controller;
  localparam int X_W = 9, Y_W = 8, COLOUR_W = 3, DEPTH = 4;

  logic                clock = 1'b0;
  logic                i_reset_n, i_chipselect, i_read, i_write, i_done;
  logic [2:0]          i_address;
  logic [31:0]         i_writedata, o_readdata;
  logic                o_waitrequest, o_go;
  logic [COLOUR_W-1:0] o_colour;
  logic [X_W-1:0]      o_X0, o_X1;
  logic [Y_W-1:0]      o_Y0, o_Y1;
`ifdef LINE_QUEUE_IRQ_EN
  logic                o_irq;
`endif

  avalon_line_queue_controller #(.X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .i_reset_n(i_reset_n), .i_chipselect(i_chipselect), .i_address(i_address),
    .i_read(i_read), .i_write(i_write), .i_writedata(i_writedata), .o_readdata(o_readdata),
    .o_waitrequest(o_waitrequest),
`ifdef LINE_QUEUE_IRQ_EN
    .o_irq(o_irq),
`endif
    .i_done(i_done), .o_go(o_go), .o_colour(o_colour),
    .o_X0(o_X0), .o_Y0(o_Y0), .o_X1(o_X1), .o_Y1(o_Y1)
  );

  always #5 clock = ~clock;

  typedef struct { int c; int x0; int y0; int x1; int y1; } cmd_t;

  cmd_t mq[$];
  cmd_t cur, stg;
  bit   m_busy, m_ovf, m_poll, m_drn;
  int   tests = 0, failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] pack(input int x, input int y);
    return 32'((y << X_W) | x);
  endfunction

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    int n = 0;
    i_chipselect = 1; i_write = 1; i_address = a; i_writedata = d;
    #1;
    while (o_waitrequest && n < 50) begin
      @(posedge clock); #1; n++;
    end
    if (n >= 50) check("wr_timeout", 32'(o_waitrequest), 32'd0);
    @(posedge clock); #1;
    i_chipselect = 0; i_write = 0; i_writedata = 0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    i_chipselect = 1; i_read = 1; i_address = a;
    #1;
    d = o_readdata;
    i_chipselect = 0; i_read = 0;
  endtask

  // Model: accepted-but-undispatched commands live in mq; the in-flight one in cur.
  function automatic void m_go();
    if (mq.size() < DEPTH) mq.push_back(stg);
    else if (m_poll) m_ovf = 1;
  endfunction

  function automatic void m_dispatch();
    if (!m_busy && mq.size() > 0) begin
      cur = mq.pop_front();
      m_busy = 1;
    end
  endfunction

  function automatic void m_reset();
    mq.delete();
    m_busy = 0; m_ovf = 0; m_poll = 0; m_drn = 0;
    cur = '{default:0};
    stg = '{default:0};
  endfunction

  task automatic done_pulse();
    i_done = 1;
    cycle();
    i_done = 0;
`ifdef LINE_QUEUE_IRQ_EN
    if (m_busy && mq.size() == 0) m_drn = 1;
`endif
    m_busy = 0;
  endtask

  task automatic stage_rand();
    stg.c  = int'($urandom_range(0, 7));
    stg.x0 = int'($urandom_range(0, 511));
    stg.y0 = int'($urandom_range(0, 255));
    stg.x1 = int'($urandom_range(0, 511));
    stg.y1 = int'($urandom_range(0, 255));
    wr(3'd5, 32'(stg.c));
    wr(3'd3, pack(stg.x0, stg.y0));
    wr(3'd4, pack(stg.x1, stg.y1));
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] v;
    logic [31:0] lvl;
    lvl = 32'(mq.size());
    rd(3'd6, v);
    check({tag, "_level"}, v, lvl);
    rd(3'd1, v);
    check({tag, "_status"}, v, (lvl << 8) | (32'(m_drn) << 2) | (32'(m_ovf) << 1) |
          32'(mq.size() == 0 && !m_busy));
  endtask

  task automatic check_cmd(input string tag);
    check({tag, "_go"}, 32'(o_go), 32'd1);
    check({tag, "_colour"}, 32'(o_colour), 32'(cur.c));
    check({tag, "_x0"}, 32'(o_X0), 32'(cur.x0));
    check({tag, "_y0"}, 32'(o_Y0), 32'(cur.y0));
    check({tag, "_x1"}, 32'(o_X1), 32'(cur.x1));
    check({tag, "_y1"}, 32'(o_Y1), 32'(cur.y1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    i_reset_n = 0; i_chipselect = 0; i_read = 0; i_write = 0; i_done = 0;
    i_address = 0; i_writedata = 0;
    m_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst_go", 32'(o_go), 32'd0);
    check("rst_wait", 32'(o_waitrequest), 32'd0);
    check("rst_rdata", o_readdata, 32'd0);
    check_regs("rst");
    i_reset_n = 1;
    cycle();

    // Single directed line
    stg = '{c:5, x0:10, y0:20, x1:100, y1:200};
    wr(3'd3, pack(10, 20)); wr(3'd4, pack(100, 200)); wr(3'd5, 32'd5);
    wr(3'd2, 32'd0); m_go();
    check("single_lat1", 32'(o_go), 32'd0);
    check_regs("single_q");
    cycle(); m_dispatch();
    check_cmd("single");
    check_regs("single_busy");
    cycle();
    done_pulse();
    check("single_done", 32'(o_go), 32'd0);
    check_regs("single_idle");

    // Register map corners
    cycle();
    rd(3'd2, v); check("rd_go_zero", v, 32'd0);
    wr(3'd7, 32'hFFFF_FFFF);
    rd(3'd7, v); check("rd_addr7", v, 32'd0);
    rd(3'd3, v); check("rd_start_kept", v, pack(10, 20));
    i_read = 1; i_address = 3'd3; #1;
    check("rd_no_cs", o_readdata, 32'd0);
    i_read = 0;
    cycle();
    wr(3'd0, 32'h1); m_poll = 1;
    rd(3'd0, v); check("rd_mode", v, 32'd1);

    // Poll-mode fill with the drawer held busy
    cycle();
    for (int k = 0; k < 6; k++) begin
      m_dispatch();
      stage_rand();
      wr(3'd2, 32'd0); m_go();
    end
    m_dispatch();
    check_cmd("fill_head");
    check_regs("fill");
    i_chipselect = 1; i_write = 1; i_address = 3'd2; #1;
    check("poll_full_wait", 32'(o_waitrequest), 32'd0);
    cycle();
    i_chipselect = 0; i_write = 0; m_go();
    wr(3'd1, 32'h2); m_ovf = 0;
    check_regs("fill_clr");

    // Stall mode on a full queue
    wr(3'd0, 32'h0); m_poll = 0;
    stg.c = int'($urandom_range(0, 7)); wr(3'd5, 32'(stg.c));
    i_chipselect = 1; i_write = 1; i_address = 3'd2; i_writedata = 0; #1;
    check("stall_wait", 32'(o_waitrequest), 32'd1);
    cycle(); cycle();
    check("stall_hold", 32'(o_waitrequest), 32'd1);
    i_done = 1; cycle(); i_done = 0; m_busy = 0;
    check("stall_gap_go", 32'(o_go), 32'd0);
    check("stall_after_done", 32'(o_waitrequest), 32'd1);
    cycle(); m_dispatch();
    check("stall_free", 32'(o_waitrequest), 32'd0);
    check_cmd("stall_next");
    cycle();
    i_chipselect = 0; i_write = 0; m_go();
    check_regs("stall_acc");

    // Back-to-back drain in FIFO order
    while (mq.size() > 0) begin
      cycle(); cycle();
      done_pulse();
      check("b2b_gap", 32'(o_go), 32'd0);
      cycle(); m_dispatch();
      check_cmd("b2b");
    end
    cycle();
    done_pulse();
    check("drain_go", 32'(o_go), 32'd0);
    check_regs("drained");

    // i_done while idle, then random lines with partial staging updates
    done_pulse();
    check_regs("idle_done");
    for (int k = 0; k < 3; k++) begin
      stg.c = int'($urandom_range(0, 7)); wr(3'd5, 32'(stg.c));
      if (k != 1) begin
        stg.x0 = int'($urandom_range(0, 511)); stg.y0 = int'($urandom_range(0, 255));
        wr(3'd3, pack(stg.x0, stg.y0));
      end
      stg.x1 = int'($urandom_range(0, 511)); stg.y1 = int'($urandom_range(0, 255));
      wr(3'd4, pack(stg.x1, stg.y1));
      wr(3'd2, 32'd0); m_go();
      check("rand_lat1", 32'(o_go), 32'd0);
      cycle(); m_dispatch();
      check_cmd("rand");
      cycle();
      done_pulse();
    end

`ifdef LINE_QUEUE_IRQ_EN
    wr(3'd1, 32'h4); m_drn = 0;
    check("irq_clr0", 32'(o_irq), 32'd0);
    wr(3'd0, 32'h2);
    stage_rand();
    wr(3'd2, 32'd0); m_go();
    wr(3'd2, 32'd0); m_go();
    m_dispatch();
    check_cmd("irq_l1");
    cycle();
    done_pulse();
    check("irq_after1", 32'(o_irq), 32'd0);
    cycle(); m_dispatch();
    check_cmd("irq_l2");
    done_pulse();
    check("irq_after2", 32'(o_irq), 32'd1);
    check_regs("irq_st");
    wr(3'd1, 32'h4); m_drn = 0;
    check("irq_clear", 32'(o_irq), 32'd0);
`endif

    // Asynchronous reset mid-draw with one more command queued
    wr(3'd0, 32'h1); m_poll = 1;
    stage_rand(); wr(3'd2, 32'd0); m_go();
    stage_rand(); wr(3'd2, 32'd0); m_go();
    m_dispatch();
    check_cmd("pre_rst");
    #3;
    i_reset_n = 0;
    #1;
    m_reset();
    check("rst_mid_go", 32'(o_go), 32'd0);
    check("rst_mid_cmd", 32'({o_colour, o_X0, o_Y0, o_X1, o_Y1}), 32'd0);
    check_regs("rst_mid");
    cycle();
    i_reset_n = 1;
    cycle(); cycle(); cycle();
    check("rst_stays_idle", 32'(o_go), 32'd0);
    rd(3'd0, v); check("rst_mode", v, 32'd0);
    check_regs("rst_after");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
